// File: rtl/mac_src_package.sv
// Shared constants and state type for the MAC operand source.
package mac_src_package;

  localparam int MAC_CNT_LEN = 4096;
  localparam int CNT_W       = $clog2(MAC_CNT_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } src_state_t;

endpackage

// File: rtl/mac_src_fifo.sv
// Single-lane operand FIFO with registered-pointer full/empty and no pass-through.
module mac_src_fifo #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DWIDTH-1:0] wdata,
  output logic              full,
  input  logic              pop,
  output logic              empty,
  output logic [DWIDTH-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mac_operand_source.sv
// Producer end of the MAC a/b/c/d streams: splits {b,a} words into lane FIFOs and closes jobs on d beats.
// Optional MAC_SRC_PERF_EN adds a stall_cnt output counting busy cycles with a/b backpressure.
module mac_operand_source #(
  parameter int DEPTH = 4,
  parameter int CNT_W = mac_src_package::CNT_W
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             start,
  input  logic             reg_simple_mul,
  input  logic [CNT_W-1:0] reg_len,
  input  logic             ld_TVALID,
  output logic             ld_TREADY,
  input  logic [63:0]      ld_TDATA,
  output logic             a_TVALID,
  input  logic             a_TREADY,
  output logic [31:0]      a_TDATA,
  output logic             b_TVALID,
  input  logic             b_TREADY,
  output logic [31:0]      b_TDATA,
  output logic             c_TVALID,
  input  logic             c_TREADY,
  output logic [31:0]      c_TDATA,
  input  logic             d_TVALID,
  output logic             d_TREADY,
  input  logic [31:0]      d_TDATA,
  output logic             busy,
  output logic             done,
  output logic             err_unexp_d,
  output logic [31:0]      last_d
`ifdef MAC_SRC_PERF_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  import mac_src_package::*;

  localparam int CW = CNT_W + 1;

  src_state_t    state;
  logic          simple_mul_q;
  logic [CW-1:0] total_q;
  logic [CW-1:0] exp_cnt;
  logic [CW-1:0] n_load;
  logic [CW-1:0] n_a;
  logic [CW-1:0] n_b;
  logic [CW-1:0] n_d;
  logic          c_pend;
  logic          full_a;
  logic          full_b;
  logic          empty_a;
  logic          empty_b;
  logic          start_go;
  logic          ld_hs;
  logic          a_hs;
  logic          b_hs;
  logic          d_hs;
  logic          drain_ok;

  assign start_go  = start & (state == IDLE);
  assign exp_cnt   = simple_mul_q ? total_q : CW'(1);
  assign ld_TREADY = (state == STREAM) & ~full_a & ~full_b & (n_load < total_q);
  assign ld_hs     = ld_TVALID & ld_TREADY;
  assign a_TVALID  = ~empty_a;
  assign b_TVALID  = ~empty_b;
  assign a_hs      = a_TVALID & a_TREADY;
  assign b_hs      = b_TVALID & b_TREADY;
  assign c_TVALID  = c_pend;
  assign c_TDATA   = '0;
  assign d_TREADY  = 1'b1;
  assign d_hs      = d_TVALID & d_TREADY;
  assign busy      = (state != IDLE);
  assign drain_ok  = (n_a == total_q) & (n_b == total_q) & (n_d == exp_cnt);

  mac_src_fifo #(.DWIDTH(32), .DEPTH(DEPTH)) u_fifo_a (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .flush (start_go),
    .push  (ld_hs),
    .wdata (ld_TDATA[31:0]),
    .full  (full_a),
    .pop   (a_TREADY),
    .empty (empty_a),
    .rdata (a_TDATA)
  );

  mac_src_fifo #(.DWIDTH(32), .DEPTH(DEPTH)) u_fifo_b (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .flush (start_go),
    .push  (ld_hs),
    .wdata (ld_TDATA[63:32]),
    .full  (full_b),
    .pop   (b_TREADY),
    .empty (empty_b),
    .rdata (b_TDATA)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state        <= IDLE;
      simple_mul_q <= 1'b0;
      total_q      <= '0;
      done         <= 1'b0;
      c_pend       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (c_TVALID & c_TREADY) c_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= STREAM;
            simple_mul_q <= reg_simple_mul;
            total_q      <= {1'b0, reg_len} + CW'(1);
            c_pend       <= 1'b1;
          end
        end
        STREAM: begin
          if (n_load == total_q) state <= DRAIN;
        end
        DRAIN: begin
          if (drain_ok) begin
            state  <= IDLE;
            done   <= 1'b1;
            c_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pop counters saturate at total so stray consumer handshakes cannot overrun.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      n_load <= '0;
      n_a    <= '0;
      n_b    <= '0;
    end else if (start_go) begin
      n_load <= '0;
      n_a    <= '0;
      n_b    <= '0;
    end else begin
      if (ld_hs)                 n_load <= n_load + 1'b1;
      if (a_hs && n_a < total_q) n_a    <= n_a + 1'b1;
      if (b_hs && n_b < total_q) n_b    <= n_b + 1'b1;
    end
  end

  // A d beat coinciding with start belongs to the new job, not to the error flag.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      n_d         <= '0;
      err_unexp_d <= 1'b0;
    end else if (start_go) begin
      err_unexp_d <= 1'b0;
      n_d         <= d_hs ? CW'(1) : '0;
    end else if (d_hs) begin
      if (state == IDLE)       err_unexp_d <= 1'b1;
      else if (n_d < exp_cnt)  n_d         <= n_d + 1'b1;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)    last_d <= '0;
    else if (d_hs) last_d <= d_TDATA;
  end

`ifdef MAC_SRC_PERF_EN
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      stall_cnt <= '0;
    end else if (start_go) begin
      stall_cnt <= '0;
    end else if (busy && ((a_TVALID && !a_TREADY) || (b_TVALID && !b_TREADY))) begin
      if (stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
